// File: rtl/edge_strobe_detector.sv
// ---------------------------------------------------------------------------
// edge_strobe_detector
//
// Turns WIDTH slow or asynchronous level inputs into one-clock event pulses.
// Each bit is passed through an optional synchroniser chain. It is then
// compared with a one-cycle history flop, so that a selected transition
// (rising, falling or both) produces exactly one registered strobe.
//
// Parameters
//   WIDTH        number of independent channels (1..32)
//   SYNC_STAGES  synchroniser flops per bit (0..4), 0 = input already synchronous
//   EDGE_MODE    0 = rising, 1 = falling, 2 = both edges
//
// Ports
//   in_clock     single clock, all state updates on its rising edge
//   in_reset     synchronous active-high reset, has priority over detection
//   in_signal    level inputs
//   out_strobe   registered one-cycle pulse per detected edge, per bit
//   out_level    synchronised level (last sync stage, or in_signal if none)
// ---------------------------------------------------------------------------
module edge_strobe_detector #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic [WIDTH-1:0] in_signal,
    output logic [WIDTH-1:0] out_strobe,
    output logic [WIDTH-1:0] out_level
);

    // Reject unsupported configurations while the design is being built,
    // rather than letting them silently produce odd hardware.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("edge_strobe_detector: WIDTH must be in 1..32");
        end
        if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("edge_strobe_detector: SYNC_STAGES must be in 0..4");
        end
        if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
            $error("edge_strobe_detector: EDGE_MODE must be 0, 1 or 2");
        end
    endgenerate

    // Level seen by the edge detector: the last synchroniser stage, or the
    // raw input when the caller guarantees it is already synchronous.
    logic [WIDTH-1:0] s_last;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];
            logic [WIDTH-1:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = in_signal;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(posedge in_clock) begin
                if (in_reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_d[i];
                    end
                end
            end

            assign s_last = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign s_last = in_signal;
        end
    endgenerate

    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_d;
    logic [WIDTH-1:0] strobe_q;
    logic [WIDTH-1:0] strobe_d;

    // History remembers the previous synchronised level. The strobe is the
    // selected difference between the current level and that history, so a
    // held level never fires twice. Back-to-back toggles each fire on their own.
    always_comb begin
        hist_d = s_last;
        case (EDGE_MODE)
            0:       strobe_d = s_last & ~hist_q;
            1:       strobe_d = ~s_last & hist_q;
            default: strobe_d = s_last ^ hist_q;
        endcase
    end

    // Clearing the history in reset makes an input that is already high at
    // release look like a fresh rising edge.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            hist_q   <= '0;
            strobe_q <= '0;
        end else begin
            hist_q   <= hist_d;
            strobe_q <= strobe_d;
        end
    end

    assign out_strobe = strobe_q;
    assign out_level  = s_last;

endmodule

// File: tb/tb_edge_strobe_detector.sv
// ---------------------------------------------------------------------------
// tb_edge_strobe_detector
//
// Drives five differently configured detectors from one shared 4-bit input
// and reset. Outputs are compared against a delay-based reference model. The
// model reasons only about "which sampled input value is visible at edge m".
// A hand-computed vector table and reset corner sequences are also checked.
// ---------------------------------------------------------------------------
module tb_edge_strobe_detector;

    localparam int NINST = 5;
    localparam int MAXSTEPS = 1024;

    // Per-instance configuration: sync stages and edge mode
    localparam int SS [NINST] = '{2, 2, 0, 3, 1};
    localparam int MM [NINST] = '{0, 1, 2, 2, 0};

    logic       clk;
    logic       rst_drv;
    logic [3:0] sig_drv;
    logic [3:0] str_o [NINST];
    logic [3:0] lvl_o [NINST];

    logic [3:0] xh [MAXSTEPS];
    logic       rh [MAXSTEPS];
    int         n_steps;
    int         errors;
    int         checks;

    typedef struct {
        logic       rst;
        logic [3:0] sig;
        logic [3:0] exp_strobe;
        logic [3:0] exp_level;
    } vec_t;

    vec_t tbl [11];

    edge_strobe_detector #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_MODE(0)) u_rise (
        .in_clock(clk), .in_reset(rst_drv), .in_signal(sig_drv),
        .out_strobe(str_o[0]), .out_level(lvl_o[0]));

    edge_strobe_detector #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_MODE(1)) u_fall (
        .in_clock(clk), .in_reset(rst_drv), .in_signal(sig_drv),
        .out_strobe(str_o[1]), .out_level(lvl_o[1]));

    edge_strobe_detector #(.WIDTH(4), .SYNC_STAGES(0), .EDGE_MODE(2)) u_both0 (
        .in_clock(clk), .in_reset(rst_drv), .in_signal(sig_drv),
        .out_strobe(str_o[2]), .out_level(lvl_o[2]));

    edge_strobe_detector #(.WIDTH(4), .SYNC_STAGES(3), .EDGE_MODE(2)) u_both3 (
        .in_clock(clk), .in_reset(rst_drv), .in_signal(sig_drv),
        .out_strobe(str_o[3]), .out_level(lvl_o[3]));

    edge_strobe_detector #(.WIDTH(4), .SYNC_STAGES(1), .EDGE_MODE(0)) u_rise1 (
        .in_clock(clk), .in_reset(rst_drv), .in_signal(sig_drv),
        .out_strobe(str_o[4]), .out_level(lvl_o[4]));

    // Free-running clock, posedges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Level the detector sees just before edge m: the input sampled s edges
    // earlier, unless a reset edge in between wiped the synchroniser.
    function automatic logic [3:0] lvlAt(input int m, input int s);
        if (s == 0) return xh[m];
        if (m - s < 0) return 4'b0000;
        for (int k = m - s; k < m; k++) begin
            if (rh[k]) return 4'b0000;
        end
        return xh[m - s];
    endfunction

    function automatic logic [3:0] expStrobe(input int m, input int s, input int mode);
        logic [3:0] cur;
        logic [3:0] prev;
        if (rh[m]) return 4'b0000;
        cur  = lvlAt(m, s);
        prev = (m == 0 || rh[m-1]) ? 4'b0000 : lvlAt(m - 1, s);
        case (mode)
            0:       return cur & ~prev;
            1:       return ~cur & prev;
            default: return cur ^ prev;
        endcase
    endfunction

    function automatic logic [3:0] expLevel(input int m, input int s);
        if (s == 0) return xh[m];
        return lvlAt(m + 1, s);
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s[%0d] at %0t: got %b, expected %b", name, idx, $time, act, exp);
        end
    endtask

    // Drive one cycle of input, wait past the edge, then check every
    // instance against the reference model.
    task automatic applyStimulus(input logic r, input logic [3:0] x);
        int m;
        rst_drv = r;
        sig_drv = x;
        m = n_steps;
        xh[m] = x;
        rh[m] = r;
        @(posedge clk);
        #1;
        for (int i = 0; i < NINST; i++) begin
            checkOutput("model_strobe", i, str_o[i], expStrobe(m, SS[i], MM[i]));
            checkOutput("model_level", i, lvl_o[i], expLevel(m, SS[i]));
        end
        n_steps++;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        n_steps = 0;
        rst_drv = 1'b1;
        sig_drv = 4'b0000;

        // Hand-computed expectations for the 2-stage rising detector:
        // reset, simultaneous rise on bits 0 and 3, fall, and re-rise on bit 0
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{1'b0, 4'b1001, 4'b0000, 4'b0000};
        tbl[3]  = '{1'b0, 4'b1001, 4'b0000, 4'b1001};
        tbl[4]  = '{1'b0, 4'b1001, 4'b1001, 4'b1001};
        tbl[5]  = '{1'b0, 4'b1001, 4'b0000, 4'b1001};
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 4'b1001};
        tbl[7]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000};
        tbl[8]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001};
        tbl[9]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001};
        tbl[10] = '{1'b0, 4'b0001, 4'b0000, 4'b0001};

        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].sig);
            checkOutput("tbl_strobe", i, str_o[0], tbl[i].exp_strobe);
            checkOutput("tbl_level", i, lvl_o[0], tbl[i].exp_level);
        end

        // Input held high, reset pulsed: the rising detector must re-strobe
        // after the normal latency, and the falling detector must stay quiet.
        applyStimulus(1'b0, 4'b0001);
        checkOutput("hold_strobe", 0, str_o[0], 4'b0000);
        applyStimulus(1'b1, 4'b0001);
        checkOutput("rst_strobe", 0, str_o[0], 4'b0000);
        checkOutput("rst_level", 0, lvl_o[0], 4'b0000);
        applyStimulus(1'b0, 4'b0001);
        checkOutput("rel1_strobe", 0, str_o[0], 4'b0000);
        checkOutput("rel1_fall", 0, str_o[1], 4'b0000);
        applyStimulus(1'b0, 4'b0001);
        checkOutput("rel2_strobe", 0, str_o[0], 4'b0000);
        checkOutput("rel2_level", 0, lvl_o[0], 4'b0001);
        applyStimulus(1'b0, 4'b0001);
        checkOutput("rel3_strobe", 0, str_o[0], 4'b0001);
        checkOutput("rel3_fall", 0, str_o[1], 4'b0000);

        // Reset arriving while the strobe is high clears everything at once
        applyStimulus(1'b1, 4'b0001);
        checkOutput("trunc_strobe", 0, str_o[0], 4'b0000);
        checkOutput("trunc_level", 0, lvl_o[0], 4'b0000);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("quiet_fall", 0, str_o[1], 4'b0000);

        // Toggle every cycle: each sampled change must strobe on its own
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, (i % 2 == 0) ? 4'b1111 : 4'b0000);
        end

        // Randomised traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
                          4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
